// File: rtl/datapath_job_arbiter_if.sv
// Job/datapath bundle for datapath_job_arbiter.
//   slave  : arbiter side (takes requests + datapath flags, drives acks,
//            response flags, status and datapath control)
//   master : environment side (requesters + datapath)
// Signals:
//   reqN, reqN_op/ra/rb/imm/useImm/rd/wb   job request N and its fields
//   ackN, resp_flags, busy, grant_id        completion / status
//   selectImm, loadReg, readRegA/B, Imm, op datapath control
//   flags                                   datapath flag register
interface datapath_job_arbiter_if #(
    parameter int OP_W   = 8,
    parameter int REG_W  = 4,
    parameter int IMM_W  = 8,
    parameter int FLAG_W = 5
);
    logic              req0,        req1;
    logic [OP_W-1:0]   req0_op,     req1_op;
    logic [REG_W-1:0]  req0_ra,     req1_ra;
    logic [REG_W-1:0]  req0_rb,     req1_rb;
    logic [IMM_W-1:0]  req0_imm,    req1_imm;
    logic              req0_useImm, req1_useImm;
    logic [REG_W-1:0]  req0_rd,     req1_rd;
    logic              req0_wb,     req1_wb;

    logic              ack0, ack1;
    logic [FLAG_W-1:0] resp_flags;
    logic              busy;
    logic              grant_id;

    logic              selectImm;
    logic [REG_W:0]    loadReg;
    logic [REG_W-1:0]  readRegA, readRegB;
    logic [IMM_W-1:0]  Imm;
    logic [OP_W-1:0]   op;
    logic [FLAG_W-1:0] flags;

    modport slave (
        input  req0, req0_op, req0_ra, req0_rb, req0_imm, req0_useImm, req0_rd, req0_wb,
        input  req1, req1_op, req1_ra, req1_rb, req1_imm, req1_useImm, req1_rd, req1_wb,
        input  flags,
        output ack0, ack1, resp_flags, busy, grant_id,
        output selectImm, loadReg, readRegA, readRegB, Imm, op
    );

    modport master (
        output req0, req0_op, req0_ra, req0_rb, req0_imm, req0_useImm, req0_rd, req0_wb,
        output req1, req1_op, req1_ra, req1_rb, req1_imm, req1_useImm, req1_rd, req1_wb,
        output flags,
        input  ack0, ack1, resp_flags, busy, grant_id,
        input  selectImm, loadReg, readRegA, readRegB, Imm, op
    );
endinterface

// File: rtl/datapath_job_arbiter.sv
// Two-requester round-robin job sequencer for the shared regfile + ALU.
// One job at a time: IDLE (pick winner) -> EXEC (drive datapath one cycle)
// -> RESP (ack winner, report flags) -> IDLE.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    datapath_job_arbiter_if.slave (requests, acks, datapath control)
module datapath_job_arbiter #(
    parameter int              OP_W   = 8,
    parameter int              REG_W  = 4,
    parameter int              IMM_W  = 8,
    parameter int              FLAG_W = 5,
    parameter logic [OP_W-1:0] NOP_OP = {OP_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    datapath_job_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q;
    logic               last_grant_q;
    logic               grant_q;
    logic               ack0_q, ack1_q, busy_q;
    logic [FLAG_W-1:0]  resp_flags_q;
    logic               selectImm_q;
    logic [REG_W:0]     loadReg_q;
    logic [REG_W-1:0]   readRegA_q, readRegB_q;
    logic [IMM_W-1:0]   Imm_q;
    logic [OP_W-1:0]    op_q;

    // Winner of the IDLE-cycle arbitration and its fields.
    logic               win_d;
    logic [OP_W-1:0]    sel_op;
    logic [REG_W-1:0]   sel_ra, sel_rb, sel_rd;
    logic [IMM_W-1:0]   sel_imm;
    logic               sel_useImm, sel_wb;

    always_comb begin
        // Tie goes to whoever did not win last; otherwise the lone requester.
        win_d = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
        if (win_d) begin
            sel_op = bus.req1_op;  sel_ra = bus.req1_ra;   sel_rb = bus.req1_rb;
            sel_imm = bus.req1_imm; sel_useImm = bus.req1_useImm;
            sel_rd = bus.req1_rd;  sel_wb = bus.req1_wb;
        end else begin
            sel_op = bus.req0_op;  sel_ra = bus.req0_ra;   sel_rb = bus.req0_rb;
            sel_imm = bus.req0_imm; sel_useImm = bus.req0_useImm;
            sel_rd = bus.req0_rd;  sel_wb = bus.req0_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            resp_flags_q <= '0;
            selectImm_q  <= 1'b0;
            loadReg_q    <= '0;
            readRegA_q   <= '0;
            readRegB_q   <= '0;
            Imm_q        <= '0;
            op_q         <= NOP_OP;
        end else begin
            // Datapath control is idle except in EXEC; the EXEC registers
            // double as the job latch, so later request changes are ignored.
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            selectImm_q <= 1'b0;
            loadReg_q   <= '0;
            readRegA_q  <= '0;
            readRegB_q  <= '0;
            Imm_q       <= '0;
            op_q        <= NOP_OP;
            case (state_q)
                IDLE: if (bus.req0 || bus.req1) begin
                    state_q      <= EXEC;
                    grant_q      <= win_d;
                    last_grant_q <= win_d;
                    busy_q       <= 1'b1;
                    selectImm_q  <= sel_useImm;
                    loadReg_q    <= {sel_wb, sel_rd};
                    readRegA_q   <= sel_ra;
                    readRegB_q   <= sel_rb;
                    Imm_q        <= sel_imm;
                    op_q         <= sel_op;
                end
                EXEC: begin
                    state_q <= RESP;
                    ack0_q  <= ~grant_q;
                    ack1_q  <= grant_q;
                end
                RESP: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    resp_flags_q <= bus.flags;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
    assign bus.selectImm = selectImm_q;
    assign bus.loadReg   = loadReg_q;
    assign bus.readRegA  = readRegA_q;
    assign bus.readRegB  = readRegB_q;
    assign bus.Imm       = Imm_q;
    assign bus.op        = op_q;
    // The datapath's flag register only reflects the job after the EXEC edge,
    // so during RESP the flags are forwarded straight from that register;
    // the copy taken on leaving RESP holds them until the next completion.
    assign bus.resp_flags = (state_q == RESP) ? bus.flags : resp_flags_q;
endmodule

// File: tb/tb_datapath_job_arbiter.sv
module tb_datapath_job_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [33:0] e;

    always #5 clk = ~clk;

    datapath_job_arbiter_if bus ();
    datapath_job_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    // Packed view: {ack0,ack1,busy,grant_id,selectImm,loadReg[4:0],readRegA,readRegB,Imm,op}
    function automatic logic [33:0] outs();
        return {bus.ack0, bus.ack1, bus.busy, bus.grant_id, bus.selectImm,
                bus.loadReg, bus.readRegA, bus.readRegB, bus.Imm, bus.op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0 = 0; bus.req0_op = 0; bus.req0_ra = 0; bus.req0_rb = 0;
        bus.req0_imm = 0; bus.req0_useImm = 0; bus.req0_rd = 0; bus.req0_wb = 0;
        bus.req1 = 0; bus.req1_op = 0; bus.req1_ra = 0; bus.req1_rb = 0;
        bus.req1_imm = 0; bus.req1_useImm = 0; bus.req1_rd = 0; bus.req1_wb = 0;
    endtask

    task automatic set_req(input int n, input logic [7:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [7:0] imm,
                           input logic use_imm, input logic [3:0] rd, input logic wb);
        if (n == 0) begin
            bus.req0_op = op; bus.req0_ra = ra; bus.req0_rb = rb; bus.req0_imm = imm;
            bus.req0_useImm = use_imm; bus.req0_rd = rd; bus.req0_wb = wb; bus.req0 = 1;
        end else begin
            bus.req1_op = op; bus.req1_ra = ra; bus.req1_rb = rb; bus.req1_imm = imm;
            bus.req1_useImm = use_imm; bus.req1_rd = rd; bus.req1_wb = wb; bus.req1 = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        bus.flags = 5'h1F;
        set_req(0, 8'hAA, 1, 2, 8'h55, 1, 3, 1);
        set_req(1, 8'hBB, 4, 5, 8'h66, 1, 6, 1);
        step(); step();
        e = 34'd0;
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL reset_outs got %h exp %h", outs(), e); end
        checks++;
        if (bus.resp_flags !== 5'h00) begin errors++; $display("FAIL reset_flags got %h exp %h", bus.resp_flags, 5'h00); end
        clear_reqs();
        bus.flags = 5'h00;
        reset = 0;
        step();
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL reset_idle got %h exp %h", outs(), e); end
    endtask

    task automatic test_single();
        set_req(0, 8'h01, 1, 2, 8'h00, 0, 3, 1);
        step();                                  // EXEC
        bus.req0_op = 8'hEE;                     // late change must be ignored
        bus.req0_ra = 4'hF;
        e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b1_0011, 4'd1, 4'd2, 8'h00, 8'h01};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t2_exec got %h exp %h", outs(), e); end
        step();                                  // RESP
        bus.flags = 5'h15;
        #1;
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t2_resp got %h exp %h", outs(), e); end
        checks++;
        if (bus.resp_flags !== 5'h15) begin errors++; $display("FAIL t2_flags got %h exp %h", bus.resp_flags, 5'h15); end
        bus.req0 = 0;
        step();                                  // IDLE
        bus.flags = 5'h0A;
        #1;
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t2_idle got %h exp %h", outs(), e); end
        checks++;
        if (bus.resp_flags !== 5'h15) begin errors++; $display("FAIL t2_flags_hold got %h exp %h", bus.resp_flags, 5'h15); end
        step();
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t2_no_rejob got %h exp %h", outs(), e); end
    endtask

    task automatic test_alternate();
        logic       g;
        logic [7:0] xop;
        logic [4:0] xld;
        logic [4:0] fl;
        reset = 1; step(); reset = 0;
        set_req(0, 8'h10, 4, 5, 8'h00, 0, 6, 1);
        set_req(1, 8'h20, 7, 8, 8'h00, 0, 9, 1);
        for (int j = 0; j < 4; j++) begin
            g   = (j % 2) == 1;
            xop = g ? 8'h20 : 8'h10;
            xld = g ? 5'b1_1001 : 5'b1_0110;
            fl  = 5'(j + 3);
            step();                              // EXEC
            e = {1'b0, 1'b0, 1'b1, g, 1'b0, xld, g ? 4'd7 : 4'd4, g ? 4'd8 : 4'd5, 8'h00, xop};
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL t3_exec%0d got %h exp %h", j, outs(), e); end
            step();                              // RESP
            bus.flags = fl;
            #1;
            e = {~g, g, 1'b1, g, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
            checks++;
            if ({outs(), bus.resp_flags} !== {e, fl}) begin
                errors++; $display("FAIL t3_resp%0d got %h/%h exp %h/%h", j, outs(), bus.resp_flags, e, fl);
            end
            step();                              // IDLE, both still requesting
            e = {1'b0, 1'b0, 1'b0, g, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL t3_idle%0d got %h exp %h", j, outs(), e); end
        end
        clear_reqs();
        step();
    endtask

    task automatic test_imm();
        set_req(1, 8'h33, 4'hA, 4'hB, 8'h7F, 1, 4'h2, 1);
        step();                                  // EXEC
        bus.req1 = 0;                            // dropped before ack: job still finishes
        e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b1_0010, 4'hA, 4'hB, 8'h7F, 8'h33};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t4_exec got %h exp %h", outs(), e); end
        step();                                  // RESP
        bus.flags = 5'h1F;
        #1;
        e = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        checks++;
        if ({outs(), bus.resp_flags} !== {e, 5'h1F}) begin
            errors++; $display("FAIL t4_resp got %h/%h exp %h/%h", outs(), bus.resp_flags, e, 5'h1F);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL t4_idle got %b exp %b", bus.busy, 1'b0); end
    endtask

    task automatic test_compare();
        set_req(0, 8'h05, 4'h1, 4'h2, 8'h00, 0, 4'h5, 0);
        step();                                  // EXEC
        bus.req0 = 0;
        e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0_0101, 4'd1, 4'd2, 8'h00, 8'h05};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t5_exec got %h exp %h", outs(), e); end
        step();                                  // RESP
        bus.flags = 5'h04;
        #1;
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        checks++;
        if ({outs(), bus.resp_flags} !== {e, 5'h04}) begin
            errors++; $display("FAIL t5_resp got %h/%h exp %h/%h", outs(), bus.resp_flags, e, 5'h04);
        end
        step();
    endtask

    task automatic test_reset_exec();
        set_req(0, 8'h07, 4'h3, 4'h4, 8'h00, 0, 4'h8, 1);
        step();                                  // EXEC
        checks++;
        if (bus.loadReg !== 5'b1_1000) begin errors++; $display("FAIL t6_exec got %b exp %b", bus.loadReg, 5'b1_1000); end
        reset = 1;
        bus.req0 = 0;
        step();
        e = 34'd0;
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t6_abort got %h exp %h", outs(), e); end
        reset = 0;
        step();
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t6_no_ack got %h exp %h", outs(), e); end
        bus.req0 = 1;                            // reissue
        step();                                  // EXEC
        bus.req0 = 0;
        e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b1_1000, 4'd3, 4'd4, 8'h00, 8'h07};
        checks++;
        if (outs() !== e) begin errors++; $display("FAIL t6_reexec got %h exp %h", outs(), e); end
        step();                                  // RESP
        bus.flags = 5'h11;
        #1;
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        checks++;
        if ({outs(), bus.resp_flags} !== {e, 5'h11}) begin
            errors++; $display("FAIL t6_resp got %h/%h exp %h/%h", outs(), bus.resp_flags, e, 5'h11);
        end
        step();
    endtask

    initial begin
        clear_reqs();
        bus.flags = 5'h00;
        reset = 1;
        test_reset();
        test_single();
        test_alternate();
        test_imm();
        test_compare();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
